apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

Sequential bridge between the single-cycle RISC-V core's load/store datapath and the SoC APB bus. It detects `lw`/`sw` accesses that fall in the peripheral address window and raises `cancel_data_memory` toward the control unit. It stalls the core while it runs a standard APB SETUP/ACCESS transfer, then returns read data for register write-back on the release cycle. Accesses outside the window pass straight through to data memory with no stall.

## Interface
Parameters:
- `NSLV`, 4: number of APB slaves; slave index is `addr[11:8]`.
- `PERIPH_BASE`, 32'h0000_1000: peripheral window base; the window is `addr[31:12] == PERIPH_BASE[31:12]`.
- `TIMEOUT`, 16: maximum ACCESS cycles before the bridge aborts the transfer.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `mem_read`  in  1  current instruction is `lw`.
- `mem_write`  in  1  current instruction is `sw`.
- `addr`  in  32  ALU result (byte address).
- `wdata`  in  32  store data (rs2).
- `cancel_data_memory`  out  1  combinational; peripheral access in progress, so suppress data-memory use.
- `stall`  out  1  combinational; freeze PC and register-file write.
- `rdata`  out  32  registered APB read data.
- `rdata_valid`  out  1  core selects `rdata` as the write-back result this cycle.
- `bus_err`  out  1  one-cycle pulse; transfer ended in error or timeout.
- `PSEL`  out  NSLV  one-hot slave select.
- `PENABLE`, `PWRITE`  out  1  APB controls.
- `PADDR`, `PWDATA`  out  32  APB address and write data.
- `PRDATA_bus`  in  NSLV*32  per-slave read data; slave i occupies bits [32i+31:32i].
- `PREADY_bus`, `PSLVERR_bus`  in  NSLV  per-slave ready and error.

## Operation
- `req = (mem_read | mem_write) & in_window`. If both strobes are high, the access is a write.
- `cancel_data_memory = req`.
- `stall = req & (state != DONE)`.
- Slave index `idx = addr[11:8]`. If `idx >= NSLV`, no PSEL is driven: IDLE goes straight to DONE with `bus_err`, and a read returns 0.
- State machine:
  - IDLE: on `req` with a valid idx, latch PADDR, PWDATA and PWRITE, and drive `PSEL[idx]`; go to SETUP.
  - SETUP: PSEL=1, PENABLE=0. Always advances to ACCESS. The timeout counter clears.
  - ACCESS: PENABLE=1. Stay until `PREADY_bus[idx]`. Then capture `PRDATA_bus[idx]` into `rdata` (reads only) and `PSLVERR_bus[idx]` into the error flag, and go to DONE. The counter increments each wait cycle. If the counter reaches `TIMEOUT-1` without PREADY, go to DONE with error and `rdata = 0`.
  - DONE: PSEL=0, PENABLE=0, stall=0 so the core retires the instruction. `rdata_valid = ~PWRITE`. `bus_err` pulses if the error flag is set. Always returns to IDLE, so the retiring instruction is never reissued.
- Back-to-back peripheral instructions: the next one is seen in IDLE on the cycle after DONE.
- PADDR, PWDATA and PWRITE hold stable from SETUP through ACCESS.
- Non-window access: the FSM stays in IDLE, and `cancel_data_memory`, `stall` and PSEL are all 0.

## Timing
- Reset (asynchronous, any state, including mid-ACCESS):
  - State goes to IDLE.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rdata=0, rdata_valid=0, bus_err=0.
  - Counter and error flag clear.
  - `stall` and `cancel_data_memory` follow their combinational inputs.
- Zero-wait transfer, with the request present in cycle t:
  - t: IDLE, stalled.
  - t+1: SETUP.
  - t+2: ACCESS with PREADY=1.
  - t+3: DONE, unstalled, `rdata_valid` for reads.
  - Four core cycles per peripheral instruction; each extra PREADY-low cycle adds one.
- Timeout: ACCESS lasts at most TIMEOUT cycles, so the worst case is TIMEOUT+3 cycles.
- PREADY is sampled only in ACCESS. PREADY from unselected slaves is ignored.

## Structure
- Shared package `soc_apb_pkg`:
  - State encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, DONE=2'd3).
  - PERIPH_BASE and window-mask constants.
  - Slave-index constants for the SoC peripherals.
- Sub-module `apb_addr_decoder`: combinational window check, idx extraction, `idx_valid` and one-hot PSEL generation. It is reused by any future second master.

## Test plan
- `sw` to 32'h0000_1104 with wdata 32'hA5A5_0001 and slave 1 PREADY=1:
  - `PSEL=4'b0010`, `PWRITE=1` in SETUP and ACCESS.
  - `stall` high for 3 cycles, `rdata_valid=0` in DONE.
- `lw` from 32'h0000_1200 with slave 2 driving PREADY after 3 wait cycles and PRDATA 32'hCAFE_F00D:
  - `rdata=32'hCAFE_F00D` and `rdata_valid=1` in DONE.
  - `stall` high for 6 cycles.
- `lw` to 32'h0000_0040 (outside the window):
  - `cancel_data_memory=0`, `stall=0`, PSEL stays 0.
- `lw` to 32'h0000_1500 (idx 5 ≥ NSLV):
  - No PSEL asserted, DONE on the next cycle with `bus_err` pulse and `rdata=0`.
- PREADY held low:
  - Abort after 16 ACCESS cycles with `bus_err`, `rdata=0` and stall released.
  - A PSLVERR=1 completion also pulses `bus_err`.
- `rst_n` asserted mid-ACCESS:
  - PSEL, PENABLE and rdata go to 0 immediately, without waiting for a clock edge.
  - After release, a new `sw` starts cleanly from IDLE.

Source files
------------

// File: rtl/soc_apb_pkg.sv
// Shared APB definitions for the SoC: bridge state encoding, peripheral window
// constants and the slave index map.
package soc_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } apb_state_e;

    localparam logic [31:0] PERIPH_BASE_DEF = 32'h0000_1000;
    localparam logic [31:0] WIN_MASK        = 32'hFFFF_F000;
    localparam int unsigned IDX_W           = 4;

    localparam int unsigned SLV_UART  = 0;
    localparam int unsigned SLV_TIMER = 1;
    localparam int unsigned SLV_GPIO  = 2;
    localparam int unsigned SLV_SPI   = 3;

endpackage

// File: rtl/apb_addr_decoder.sv
// Peripheral window check and one-hot slave select generation, shared by any
// APB master in the SoC. Takes the address page (addr[31:8]).
module apb_addr_decoder
    import soc_apb_pkg::*;
#(
    parameter int unsigned NSLV        = 4,
    parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF
) (
    input  logic [23:0]     page,
    output logic            in_window,
    output logic            idx_valid,
    output logic [NSLV-1:0] psel
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        in_window = (({page, 8'h00} & WIN_MASK) == (PERIPH_BASE & WIN_MASK));
        idx       = page[IDX_W-1:0];
        idx_valid = in_window && (32'(idx) < NSLV);
        psel      = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            psel[i] = idx_valid && (32'(idx) == i);
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Stalling bridge from the core's load/store path to the APB bus: runs one
// SETUP/ACCESS transfer per peripheral lw/sw and returns read data on release.
module apb_master_bridge
    import soc_apb_pkg::*;
#(
    parameter int unsigned NSLV        = 4,
    parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             cancel_data_memory,
    output logic             stall,
    output logic [31:0]      rdata,
    output logic             rdata_valid,
    output logic             bus_err,
    output logic [NSLV-1:0]  PSEL,
    output logic             PENABLE,
    output logic             PWRITE,
    output logic [31:0]      PADDR,
    output logic [31:0]      PWDATA,
    input  logic [NSLV*32-1:0] PRDATA_bus,
    input  logic [NSLV-1:0]  PREADY_bus,
    input  logic [NSLV-1:0]  PSLVERR_bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    apb_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NSLV-1:0] psel_d;
    logic            penable_d, pwrite_d, rdata_valid_d, bus_err_d;
    logic [31:0]     paddr_d, pwdata_d, rdata_d;

    logic            in_window, idx_valid, req;
    logic [NSLV-1:0] dec_psel;
    logic            pready_sel, pslverr_sel;
    logic [31:0]     prdata_sel;
    logic [31:0]     prdata_arr [NSLV];

    apb_addr_decoder #(
        .NSLV        (NSLV),
        .PERIPH_BASE (PERIPH_BASE)
    ) u_dec (
        .page      (addr[31:8]),
        .in_window (in_window),
        .idx_valid (idx_valid),
        .psel      (dec_psel)
    );

    assign req                = (mem_read | mem_write) & in_window;
    assign cancel_data_memory = req;
    assign stall              = req & (state_q != DONE);

    for (genvar i = 0; i < NSLV; i++) begin : g_unpack
        assign prdata_arr[i] = PRDATA_bus[32*i +: 32];
    end

    // Response mux keyed by the latched one-hot PSEL, so unselected slaves are ignored
    always_comb begin
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        prdata_sel  = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (PSEL[i]) begin
                pready_sel  = pready_sel  | PREADY_bus[i];
                pslverr_sel = pslverr_sel | PSLVERR_bus[i];
                prdata_sel  = prdata_sel  | prdata_arr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            PSEL        <= '0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            PSEL        <= psel_d;
            PENABLE     <= penable_d;
            PWRITE      <= pwrite_d;
            PADDR       <= paddr_d;
            PWDATA      <= pwdata_d;
            rdata       <= rdata_d;
            rdata_valid <= rdata_valid_d;
            bus_err     <= bus_err_d;
        end
    end

    // rdata_valid and bus_err are set on entry to DONE, so they last exactly the DONE cycle
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        psel_d        = PSEL;
        penable_d     = PENABLE;
        pwrite_d      = PWRITE;
        paddr_d       = PADDR;
        pwdata_d      = PWDATA;
        rdata_d       = rdata;
        rdata_valid_d = 1'b0;
        bus_err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (idx_valid) begin
                        state_d  = SETUP;
                        psel_d   = dec_psel;
                        paddr_d  = addr;
                        pwdata_d = wdata;
                        pwrite_d = mem_write;
                    end else begin
                        // no such slave: retire immediately with an error
                        state_d       = DONE;
                        bus_err_d     = 1'b1;
                        rdata_valid_d = ~mem_write;
                        if (!mem_write) begin
                            rdata_d = '0;
                        end
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                if (pready_sel) begin
                    state_d       = DONE;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    bus_err_d     = pslverr_sel;
                    rdata_valid_d = ~PWRITE;
                    if (!PWRITE) begin
                        rdata_d = prdata_sel;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d       = DONE;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    bus_err_d     = 1'b1;
                    rdata_valid_d = ~PWRITE;
                    rdata_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: a configurable APB slave plus a
// transaction-level reference model of latency, error and read-back results.
module tb_apb_master_bridge;
    import soc_apb_pkg::*;

    localparam int unsigned NSLV    = 4;
    localparam int unsigned TIMEOUT = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 mem_read, mem_write;
    logic [31:0]          addr, wdata;
    logic                 cancel_data_memory, stall;
    logic [31:0]          rdata;
    logic                 rdata_valid, bus_err;
    logic [NSLV-1:0]      PSEL;
    logic                 PENABLE, PWRITE;
    logic [31:0]          PADDR, PWDATA;
    logic [NSLV*32-1:0]   PRDATA_bus;
    logic [NSLV-1:0]      PREADY_bus, PSLVERR_bus;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] model_rdata = '0;

    logic [7:0]  cfg_wait  = '0;
    logic        cfg_err   = 1'b0;
    logic [31:0] cfg_rdata = '0;
    logic [7:0]  acnt;

    always #5 clk = ~clk;

    apb_master_bridge #(
        .NSLV        (NSLV),
        .PERIPH_BASE (32'h0000_1000),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .addr               (addr),
        .wdata              (wdata),
        .cancel_data_memory (cancel_data_memory),
        .stall              (stall),
        .rdata              (rdata),
        .rdata_valid        (rdata_valid),
        .bus_err            (bus_err),
        .PSEL               (PSEL),
        .PENABLE            (PENABLE),
        .PWRITE             (PWRITE),
        .PADDR              (PADDR),
        .PWDATA             (PWDATA),
        .PRDATA_bus         (PRDATA_bus),
        .PREADY_bus         (PREADY_bus),
        .PSLVERR_bus        (PSLVERR_bus)
    );

    // Slave: selected one answers after cfg_wait wait cycles; others drive misleading values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acnt <= '0;
        else if (PENABLE && (|PSEL) && !(|(PREADY_bus & PSEL))) acnt <= acnt + 8'd1;
        else acnt <= '0;
    end

    always_comb begin
        for (int i = 0; i < int'(NSLV); i++) begin
            PREADY_bus[i]            = PSEL[i] ? (PENABLE && (acnt == cfg_wait)) : 1'b1;
            PSLVERR_bus[i]           = PSEL[i] ? cfg_err : 1'b1;
            PRDATA_bus[32*i +: 32]   = PSEL[i] ? cfg_rdata : ~cfg_rdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One lw/sw with the slave configured as given; expectations come from transaction rules
    task automatic run_txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input int waits, input bit err, input logic [31:0] rd);
        bit win, valid, exp_err;
        int idx, exp_stall, n;
        logic [31:0] exp_psel;
        win   = (a[31:12] == 20'h00001);
        idx   = int'(a[11:8]);
        valid = win && (idx < int'(NSLV));
        exp_psel = valid ? (32'd1 << idx) : 32'd0;
        if (!win)                       exp_stall = 0;
        else if (!valid)                exp_stall = 1;
        else if (waits >= int'(TIMEOUT)) exp_stall = 2 + int'(TIMEOUT);
        else                            exp_stall = 3 + waits;
        exp_err = win && (!valid || waits >= int'(TIMEOUT) || err);
        if (win && !wr) model_rdata = (valid && waits < int'(TIMEOUT)) ? rd : 32'd0;
        else if (win && wr && valid && waits >= int'(TIMEOUT)) model_rdata = 32'd0;

        @(negedge clk);
        cfg_wait  = (waits > 255) ? 8'd255 : 8'(waits);
        cfg_err   = err;
        cfg_rdata = rd;
        mem_write = wr;
        mem_read  = !wr;
        addr      = a;
        wdata     = wd;
        #1;
        chk("cancel", 32'(cancel_data_memory), 32'(win));
        n = 0;
        for (int c = 0; c < 40 && stall; c++) begin
            n++;
            if (n == 2) begin
                chk("setup_psel", 32'(PSEL), exp_psel);
                chk("setup_penable", 32'(PENABLE), 32'd0);
                chk("setup_pwrite", 32'(PWRITE), 32'(wr));
                chk("setup_paddr", PADDR, a);
                chk("setup_pwdata", PWDATA, wd);
            end
            if (n == 3) begin
                chk("access_penable", 32'(PENABLE), 32'd1);
                chk("access_paddr", PADDR, a);
            end
            @(posedge clk);
            #1;
        end
        chk("stall_cycles", 32'(n), 32'(exp_stall));
        chk("done_psel", 32'(PSEL), 32'd0);
        chk("done_penable", 32'(PENABLE), 32'd0);
        if (win) begin
            chk("done_bus_err", 32'(bus_err), 32'(exp_err));
            chk("done_rvalid", 32'(rdata_valid), 32'(!wr));
            chk("done_rdata", rdata, model_rdata);
        end
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        chk("post_bus_err", 32'(bus_err), 32'd0);
        chk("post_rvalid", 32'(rdata_valid), 32'd0);
        chk("post_psel", 32'(PSEL), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        #12;
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rvalid", 32'(rdata_valid), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed cases
        run_txn(1'b1, {20'h00001, 4'(SLV_TIMER), 8'h04}, 32'hA5A5_0001, 0, 1'b0, 32'h1111_2222);
        run_txn(1'b0, {20'h00001, 4'(SLV_GPIO), 8'h00}, 32'h0, 3, 1'b0, 32'hCAFE_F00D);
        run_txn(1'b0, 32'h0000_0040, 32'h0, 0, 1'b0, 32'h0);
        run_txn(1'b0, 32'h0000_1500, 32'h0, 0, 1'b0, 32'h0);
        run_txn(1'b0, {20'h00001, 4'(SLV_UART), 8'h10}, 32'h0, 255, 1'b0, 32'hDEAD_BEEF);
        run_txn(1'b0, {20'h00001, 4'(SLV_SPI), 8'h08}, 32'h0, 15, 1'b0, 32'h1234_5678);
        run_txn(1'b1, {20'h00001, 4'(SLV_SPI), 8'h0C}, 32'h0BAD_0BAD, 1, 1'b1, 32'h0);

        // asynchronous reset in the middle of ACCESS
        run_txn(1'b0, {20'h00001, 4'(SLV_GPIO), 8'h04}, 32'h0, 0, 1'b0, 32'h7777_8888);
        @(negedge clk);
        cfg_wait = 8'd10; cfg_err = 1'b0; mem_read = 1'b1; addr = 32'h0000_1208;
        repeat (4) @(posedge clk);
        #2;
        chk("pre_rst_penable", 32'(PENABLE), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_psel", 32'(PSEL), 32'd0);
        chk("arst_penable", 32'(PENABLE), 32'd0);
        chk("arst_rdata", rdata, 32'd0);
        chk("arst_stall", 32'(stall), 32'd1);
        chk("arst_cancel", 32'(cancel_data_memory), 32'd1);
        @(negedge clk);
        mem_read = 1'b0;
        #1;
        chk("arst_stall_idle", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_rdata = '0;
        run_txn(1'b1, {20'h00001, 4'(SLV_TIMER), 8'h00}, 32'h5555_AAAA, 2, 1'b0, 32'h0);

        // random mix
        for (int k = 0; k < 40; k++) begin
            int w;
            if ($urandom_range(0, 9) < 7) begin
                a = {20'h00001, 4'($urandom_range(0, 5)), 8'($urandom)};
            end else begin
                a = $urandom;
                if (a[31:12] == 20'h00001) a[20] = 1'b1;
            end
            w = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 5));
            run_txn(1'($urandom), a, $urandom, w, ($urandom_range(0, 7) == 0), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
